// File: rtl/id_pipe_stage.sv
// id_pipe_stage -- pipelined LA32 instruction-decode stage.
//
// Holds one instruction in a stage register between IF and EXE with
// valid/allowin handshakes, decodes it, reads the 32-entry register file,
// resolves RAW hazards against EXE/MEM/WB and resolves branches/jumps,
// issuing a one-cycle redirect (br_taken/br_target) back to IF.
//
// Ports:
//   clk, resetn                     clock (rising edge), async active-low reset
//   fs_to_ds_valid, fs_pc, fs_inst  instruction offered by IF
//   ds_allowin                      ID can accept this cycle
//   es_allowin                      EXE can accept this cycle
//   ds_to_es_valid, ds_pc, ds_*     decoded instruction handed to EXE
//   br_taken, br_target             redirect to IF
//   es_*/ms_*/wb_*                  downstream stage state for hazards/forwarding;
//                                   wb_* also drives the register-file write port
//
// Build option: define ID_BYPASS_EN to enable the forwarding network
// (stall on load-use only). Without it, any pending write to a used source
// stalls ID until the value has been written into the register file.
module id_pipe_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 12,
  parameter int NREG     = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                fs_to_ds_valid,
  input  logic [XLEN-1:0]     fs_pc,
  input  logic [31:0]         fs_inst,
  output logic                ds_allowin,
  input  logic                es_allowin,
  output logic                ds_to_es_valid,
  output logic [XLEN-1:0]     ds_pc,
  output logic [ALU_OP_W-1:0] ds_alu_op,
  output logic                ds_src1_is_pc,
  output logic                ds_src2_is_imm,
  output logic [XLEN-1:0]     ds_imm,
  output logic [XLEN-1:0]     ds_rj_value,
  output logic [XLEN-1:0]     ds_rkd_value,
  output logic                ds_res_from_mem,
  output logic                ds_mem_we,
  output logic                ds_gr_we,
  output logic [4:0]          ds_dest,
  output logic                br_taken,
  output logic [XLEN-1:0]     br_target,
  input  logic                es_valid,
  input  logic                es_gr_we,
  input  logic                es_res_from_mem,
  input  logic [4:0]          es_dest,
  input  logic [XLEN-1:0]     es_result,
  input  logic                ms_valid,
  input  logic                ms_gr_we,
  input  logic [4:0]          ms_dest,
  input  logic [XLEN-1:0]     ms_result,
  input  logic                wb_valid,
  input  logic                wb_gr_we,
  input  logic [4:0]          wb_dest,
  input  logic [XLEN-1:0]     wb_final_result
);

  logic        ds_valid;
  logic [31:0] ds_inst;
  logic        ds_ready_go;

  // ---------------- stage register ----------------
  assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid & ds_ready_go;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid <= 1'b0;
      ds_pc    <= '0;
      ds_inst  <= '0;
    end else if (ds_allowin) begin
      // An instruction offered on the redirect edge is on the wrong path.
      ds_valid <= fs_to_ds_valid & ~br_taken;
      if (fs_to_ds_valid) begin
        ds_pc   <= fs_pc;
        ds_inst <= fs_inst;
      end
    end
  end

  // ---------------- field extraction / decode ----------------
  logic [4:0]  rd, rj, rk;
  logic [11:0] si12;
  logic [15:0] off16;
  logic [25:0] off26;
  logic [19:0] si20;

  assign rd    = ds_inst[4:0];
  assign rj    = ds_inst[9:5];
  assign rk    = ds_inst[14:10];   // also ui5 for the shift-immediate forms
  assign si12  = ds_inst[21:10];
  assign off16 = ds_inst[25:10];
  assign off26 = {ds_inst[9:0], ds_inst[25:10]};
  assign si20  = ds_inst[24:5];

  logic inst_add, inst_sub, inst_slt, inst_sltu, inst_nor, inst_and, inst_or, inst_xor;
  logic inst_slli, inst_srli, inst_srai, inst_addi, inst_ld, inst_st;
  logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne, inst_lu12i;

  assign inst_add   = ds_inst[31:15] == 17'h00020;
  assign inst_sub   = ds_inst[31:15] == 17'h00022;
  assign inst_slt   = ds_inst[31:15] == 17'h00024;
  assign inst_sltu  = ds_inst[31:15] == 17'h00025;
  assign inst_nor   = ds_inst[31:15] == 17'h00028;
  assign inst_and   = ds_inst[31:15] == 17'h00029;
  assign inst_or    = ds_inst[31:15] == 17'h0002a;
  assign inst_xor   = ds_inst[31:15] == 17'h0002b;
  assign inst_slli  = ds_inst[31:15] == 17'h00081;
  assign inst_srli  = ds_inst[31:15] == 17'h00089;
  assign inst_srai  = ds_inst[31:15] == 17'h00091;
  assign inst_addi  = ds_inst[31:22] == 10'h00a;
  assign inst_ld    = ds_inst[31:22] == 10'h0a2;
  assign inst_st    = ds_inst[31:22] == 10'h0a6;
  assign inst_jirl  = ds_inst[31:26] == 6'h13;
  assign inst_b     = ds_inst[31:26] == 6'h14;
  assign inst_bl    = ds_inst[31:26] == 6'h15;
  assign inst_beq   = ds_inst[31:26] == 6'h16;
  assign inst_bne   = ds_inst[31:26] == 6'h17;
  assign inst_lu12i = ds_inst[31:25] == 7'h0a;

  logic is_3r, is_shift, is_mem_addr, uses_rd_as_src;
  assign is_3r          = inst_add | inst_sub | inst_slt | inst_sltu |
                          inst_nor | inst_and | inst_or  | inst_xor;
  assign is_shift       = inst_slli | inst_srli | inst_srai;
  assign is_mem_addr    = inst_addi | inst_ld | inst_st;
  assign uses_rd_as_src = inst_st | inst_beq | inst_bne;

  logic [ALU_OP_W-1:0] alu_op;
  always_comb begin
    alu_op     = '0;
    alu_op[0]  = inst_add | is_mem_addr | inst_jirl | inst_bl;
    alu_op[1]  = inst_sub;
    alu_op[2]  = inst_slt;
    alu_op[3]  = inst_sltu;
    alu_op[4]  = inst_and;
    alu_op[5]  = inst_nor;
    alu_op[6]  = inst_or;
    alu_op[7]  = inst_xor;
    alu_op[8]  = inst_slli;
    alu_op[9]  = inst_srli;
    alu_op[10] = inst_srai;
    alu_op[11] = inst_lu12i;
  end

  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    ds_imm = '0;
    if (inst_jirl | inst_bl)  ds_imm = XLEN'(4);
    else if (inst_lu12i)      ds_imm = XLEN'($signed({si20, 12'b0}));
    else if (is_shift)        ds_imm = XLEN'(rk);
    else if (is_mem_addr)     ds_imm = XLEN'($signed(si12));
  end

  assign ds_alu_op       = alu_op & {ALU_OP_W{ds_valid}};
  assign ds_src1_is_pc   = ds_valid & (inst_jirl | inst_bl);
  assign ds_src2_is_imm  = ds_valid & (is_shift | is_mem_addr | inst_lu12i | inst_jirl | inst_bl);
  assign ds_res_from_mem = ds_valid & inst_ld;
  assign ds_mem_we       = ds_valid & inst_st;
  assign ds_gr_we        = ds_valid & (is_3r | is_shift | inst_addi | inst_ld |
                                       inst_lu12i | inst_jirl | inst_bl);
  assign ds_dest         = inst_bl ? 5'd1 : rd;

  // ---------------- register file ----------------
  logic [XLEN-1:0] rf [NREG];
  logic [4:0]      rkd_addr;
  logic [XLEN-1:0] rf_rj, rf_rkd;

  // NOTE: the register file is deliberately not reset; software initialises
  // it and r0 is forced to zero on read instead of stored.
  always_ff @(posedge clk) begin
    if (wb_valid & wb_gr_we & (wb_dest != 5'd0))
      rf[wb_dest] <= wb_final_result;
  end

  assign rkd_addr = uses_rd_as_src ? rd : rk;
  assign rf_rj    = (rj == 5'd0)       ? '0 : rf[rj];
  assign rf_rkd   = (rkd_addr == 5'd0) ? '0 : rf[rkd_addr];

  // ---------------- hazards / forwarding ----------------
  logic rj_used, rkd_used;
  logic es_rj_hit, ms_rj_hit, wb_rj_hit, es_rkd_hit, ms_rkd_hit, wb_rkd_hit;

  assign rj_used  = is_3r | is_shift | is_mem_addr | inst_jirl | inst_beq | inst_bne;
  assign rkd_used = is_3r | uses_rd_as_src;

  assign es_rj_hit  = es_valid & es_gr_we & (es_dest != 5'd0) & (es_dest == rj);
  assign ms_rj_hit  = ms_valid & ms_gr_we & (ms_dest != 5'd0) & (ms_dest == rj);
  assign wb_rj_hit  = wb_valid & wb_gr_we & (wb_dest != 5'd0) & (wb_dest == rj);
  assign es_rkd_hit = es_valid & es_gr_we & (es_dest != 5'd0) & (es_dest == rkd_addr);
  assign ms_rkd_hit = ms_valid & ms_gr_we & (ms_dest != 5'd0) & (ms_dest == rkd_addr);
  assign wb_rkd_hit = wb_valid & wb_gr_we & (wb_dest != 5'd0) & (wb_dest == rkd_addr);

`ifdef ID_BYPASS_EN
  // Only a load in EXE has no value yet; everything else is forwarded,
  // youngest producer first.
  assign ds_ready_go  = ~(es_res_from_mem & ((rj_used & es_rj_hit) | (rkd_used & es_rkd_hit)));
  assign ds_rj_value  = es_rj_hit  ? es_result :
                        ms_rj_hit  ? ms_result :
                        wb_rj_hit  ? wb_final_result : rf_rj;
  assign ds_rkd_value = es_rkd_hit ? es_result :
                        ms_rkd_hit ? ms_result :
                        wb_rkd_hit ? wb_final_result : rf_rkd;
`else
  // No forwarding: wait until the producer has left WB and its value sits
  // in the register file.
  assign ds_ready_go  = ~((rj_used  & (es_rj_hit  | ms_rj_hit  | wb_rj_hit)) |
                          (rkd_used & (es_rkd_hit | ms_rkd_hit | wb_rkd_hit)));
  assign ds_rj_value  = rf_rj;
  assign ds_rkd_value = rf_rkd;

  logic unused_fwd;
  assign unused_fwd = ^{es_res_from_mem, es_result, ms_result};
`endif

  // ---------------- branch resolution ----------------
  logic rs_eq;
  assign rs_eq    = ds_rj_value == ds_rkd_value;
  assign br_taken = ds_valid & ds_ready_go & es_allowin &
                    ((inst_beq & rs_eq) | (inst_bne & ~rs_eq) | inst_jirl | inst_b | inst_bl);

  always_comb begin
    br_target = ds_pc + XLEN'($signed({off16, 2'b00}));
    if (inst_b | inst_bl)  br_target = ds_pc + XLEN'($signed({off26, 2'b00}));
    else if (inst_jirl)    br_target = ds_rj_value + XLEN'($signed({off16, 2'b00}));
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
module tb_id_pipe_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc, fs_inst;
  logic        ds_allowin, es_allowin, ds_to_es_valid;
  logic [31:0] ds_pc;
  logic [11:0] ds_alu_op;
  logic        ds_src1_is_pc, ds_src2_is_imm;
  logic [31:0] ds_imm, ds_rj_value, ds_rkd_value;
  logic        ds_res_from_mem, ds_mem_we, ds_gr_we;
  logic [4:0]  ds_dest;
  logic        br_taken;
  logic [31:0] br_target;
  logic        es_valid, es_gr_we, es_res_from_mem;
  logic [4:0]  es_dest;
  logic [31:0] es_result;
  logic        ms_valid, ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        wb_valid, wb_gr_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_final_result;

  id_pipe_stage dut (
    .clk(clk), .resetn(resetn),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
    .ds_pc(ds_pc), .ds_alu_op(ds_alu_op), .ds_src1_is_pc(ds_src1_is_pc),
    .ds_src2_is_imm(ds_src2_is_imm), .ds_imm(ds_imm), .ds_rj_value(ds_rj_value),
    .ds_rkd_value(ds_rkd_value), .ds_res_from_mem(ds_res_from_mem), .ds_mem_we(ds_mem_we),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .br_taken(br_taken), .br_target(br_target),
    .es_valid(es_valid), .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem),
    .es_dest(es_dest), .es_result(es_result),
    .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .wb_valid(wb_valid), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest),
    .wb_final_result(wb_final_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One decode vector: stimulus plus every expected output.
  typedef struct {
    logic [31:0] pc, inst;
    logic [11:0] alu;
    logic [4:0]  ctl;      // {src1_is_pc, src2_is_imm, res_from_mem, mem_we, gr_we}
    logic [31:0] imm;
    logic [4:0]  dest;     // compared only when gr_we expected
    logic        br;
    logic [31:0] tgt;      // compared only when br expected
    logic        crj;
    logic [31:0] rj;
    logic        crkd;
    logic [31:0] rkd;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb_q[$];
  int          id_q[$];
  logic [31:0] exp_rf [32];

  task automatic add(input logic [31:0] pc, inst, input logic [11:0] alu, input logic [4:0] ctl,
                     input logic [31:0] imm, input logic [4:0] dest, input logic br,
                     input logic [31:0] tgt, input logic crj, input logic [31:0] rj,
                     input logic crkd, input logic [31:0] rkd);
    vec_t v;
    v.pc = pc; v.inst = inst; v.alu = alu; v.ctl = ctl; v.imm = imm; v.dest = dest;
    v.br = br; v.tgt = tgt; v.crj = crj; v.rj = rj; v.crkd = crkd; v.rkd = rkd;
    vecs.push_back(v);
  endtask

  task automatic cmp_vec(input int id, input vec_t e);
    string p;
    p = $sformatf("v%0d", id);
    check({p, " pc"},       ds_pc, e.pc);
    check({p, " alu_op"},   32'(ds_alu_op), 32'(e.alu));
    check({p, " ctl"},      32'({ds_src1_is_pc, ds_src2_is_imm, ds_res_from_mem, ds_mem_we, ds_gr_we}),
          32'(e.ctl));
    check({p, " imm"},      ds_imm, e.imm);
    check({p, " br_taken"}, 32'(br_taken), 32'(e.br));
    if (e.ctl[0]) check({p, " dest"},      32'(ds_dest), 32'(e.dest));
    if (e.br)     check({p, " br_target"}, br_target, e.tgt);
    if (e.crj)    check({p, " rj"},        ds_rj_value, e.rj);
    if (e.crkd)   check({p, " rkd"},       ds_rkd_value, e.rkd);
  endtask

  task automatic idle_stages();
    es_valid = 0; es_gr_we = 0; es_res_from_mem = 0; es_dest = 0; es_result = 0;
    ms_valid = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0;
    wb_valid = 0; wb_gr_we = 0; wb_dest = 0; wb_final_result = 0;
  endtask

  initial begin
    // ---------------- reset and reset mid-operation ----------------
    resetn = 0; fs_to_ds_valid = 0; fs_pc = 0; fs_inst = 0; es_allowin = 1;
    idle_stages();
    #1;
    check("rst to_es_valid", 32'(ds_to_es_valid), 0);
    check("rst allowin",     32'(ds_allowin), 1);
    check("rst br_taken",    32'(br_taken), 0);
    check("rst gr_we",       32'(ds_gr_we), 0);
    check("rst mem_we",      32'(ds_mem_we), 0);
    @(negedge clk) resetn = 1;
    @(negedge clk) begin fs_to_ds_valid = 1; fs_pc = 32'h1C00_0040; fs_inst = 32'h0010_0823; end
    @(negedge clk) begin fs_to_ds_valid = 0; es_allowin = 0; end
    #1 check("pre-reset to_es_valid", 32'(ds_to_es_valid), 1);
    #2 resetn = 0;
    #1;
    check("midrst to_es_valid", 32'(ds_to_es_valid), 0);
    check("midrst allowin",     32'(ds_allowin), 1);
    check("midrst gr_we",       32'(ds_gr_we), 0);
    check("midrst pc",          ds_pc, 0);
    @(negedge clk) begin resetn = 1; es_allowin = 1; end
    repeat (2) begin
      @(negedge clk);
      check("post-rst no handoff", 32'(ds_to_es_valid), 0);
    end

    // ---------------- register-file preload through WB ----------------
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'hA5A5_0000 | 32'(i);
    exp_rf[1] = 32'd5;  exp_rf[2] = 32'd7;  exp_rf[4] = 32'h1C00_0100;
    exp_rf[5] = 32'hFFFF_FFF0; exp_rf[6] = 32'h8000_0000; exp_rf[7] = 32'd3;
    exp_rf[9] = 32'd9;  exp_rf[10] = 32'hFF; exp_rf[11] = 32'h1234_5678;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      wb_valid = 1; wb_gr_we = 1; wb_dest = 5'(i);
      wb_final_result = (i == 0) ? 32'hFFFF_FFFF : exp_rf[i];
    end
    exp_rf[0] = 32'h0;
    @(negedge clk) idle_stages();

    // ---------------- decode table ----------------
    //   pc            inst          alu     ctl       imm           dst br tgt           crj rj            crkd rkd
    add(32'h1C000000, 32'h00100823, 12'h001, 5'b00001, 32'h0,        3, 0, 32'h0,        1, exp_rf[1],  1, exp_rf[2]);
    add(32'h1C000004, 32'h00110828, 12'h002, 5'b00001, 32'h0,        8, 0, 32'h0,        1, exp_rf[1],  1, exp_rf[2]);
    add(32'h1C000008, 32'h001204A8, 12'h004, 5'b00001, 32'h0,        8, 0, 32'h0,        1, exp_rf[5],  1, exp_rf[1]);
    add(32'h1C00000C, 32'h00129CC8, 12'h008, 5'b00001, 32'h0,        8, 0, 32'h0,        1, exp_rf[6],  1, exp_rf[7]);
    add(32'h1C000014, 32'h0014AD48, 12'h010, 5'b00001, 32'h0,        8, 0, 32'h0,        1, exp_rf[10], 1, exp_rf[11]);
    add(32'h1C000018, 32'h00140828, 12'h020, 5'b00001, 32'h0,        8, 0, 32'h0,        1, exp_rf[1],  1, exp_rf[2]);
    add(32'h1C00001C, 32'h00150828, 12'h040, 5'b00001, 32'h0,        8, 0, 32'h0,        1, exp_rf[1],  1, exp_rf[2]);
    add(32'h1C000020, 32'h00158828, 12'h080, 5'b00001, 32'h0,        8, 0, 32'h0,        1, exp_rf[1],  1, exp_rf[2]);
    add(32'h1C000024, 32'h00408C28, 12'h100, 5'b01001, 32'd3,        8, 0, 32'h0,        1, exp_rf[1],  0, 32'h0);
    add(32'h1C000028, 32'h0044FCC8, 12'h200, 5'b01001, 32'd31,       8, 0, 32'h0,        1, exp_rf[6],  0, 32'h0);
    add(32'h1C00002C, 32'h004884C8, 12'h400, 5'b01001, 32'd1,        8, 0, 32'h0,        1, exp_rf[6],  0, 32'h0);
    add(32'h1C000030, 32'h02BFFC28, 12'h001, 5'b01001, 32'hFFFFFFFF, 8, 0, 32'h0,        1, exp_rf[1],  0, 32'h0);
    add(32'h1C000034, 32'h2880402C, 12'h001, 5'b01101, 32'h10,      12, 0, 32'h0,        1, exp_rf[1],  0, 32'h0);
    add(32'h1C000038, 32'h299FF022, 12'h001, 5'b01010, 32'h7FC,      2, 0, 32'h0,        1, exp_rf[1],  1, exp_rf[2]);
    add(32'h1C00003C, 32'h1500002D, 12'h800, 5'b01001, 32'h80001000,13, 0, 32'h0,        0, 32'h0,      0, 32'h0);
    add(32'h1C000010, 32'h58001129, 12'h000, 5'b00000, 32'h0,        0, 1, 32'h1C000020, 1, exp_rf[9],  1, exp_rf[9]);
    add(32'h1C000100, 32'h5FFFFC22, 12'h000, 5'b00000, 32'h0,        0, 1, 32'h1C0000FC, 1, exp_rf[1],  1, exp_rf[2]);
    add(32'h1C000010, 32'h5C001129, 12'h000, 5'b00000, 32'h0,        0, 0, 32'h0,        1, exp_rf[9],  1, exp_rf[9]);
    add(32'h1C000010, 32'h58001022, 12'h000, 5'b00000, 32'h0,        0, 0, 32'h0,        1, exp_rf[1],  1, exp_rf[2]);
    add(32'h1C000300, 32'h4C000881, 12'h001, 5'b11001, 32'd4,        1, 1, 32'h1C000108, 1, exp_rf[4],  0, 32'h0);
    add(32'h1C000200, 32'h53FFFBFF, 12'h000, 5'b00000, 32'h0,        0, 1, 32'h1C0001F8, 0, 32'h0,      0, 32'h0);
    add(32'h1C000000, 32'h54000010, 12'h001, 5'b11001, 32'd4,        1, 1, 32'h1C400000, 0, 32'h0,      0, 32'h0);
    add(32'h1C000400, 32'hFFFFFFFF, 12'h000, 5'b00000, 32'h0,        0, 0, 32'h0,        0, 32'h0,      0, 32'h0);

    // Stream the table back to back; after a taken branch the next offer is
    // a wrong-path instruction that must be dropped.
    begin
      int   idx   = 0;
      int   guard = 0;
      logic drop;
      vec_t e;
      while ((idx < vecs.size() || sb_q.size() != 0) && guard < 200) begin
        @(negedge clk);
        guard++;
        drop = 0;
        if (ds_to_es_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected handoff", 32'(ds_to_es_valid), 0);
          end else begin
            e = sb_q.pop_front();
            cmp_vec(id_q.pop_front(), e);
            drop = e.br;
          end
        end else begin
          check("idle br_taken", 32'(br_taken), 0);
        end
        if (drop) begin
          fs_to_ds_valid = 1; fs_pc = 32'hDEAD_0000; fs_inst = 32'h0010_0823;
        end else if (idx < vecs.size()) begin
          fs_to_ds_valid = 1; fs_pc = vecs[idx].pc; fs_inst = vecs[idx].inst;
          sb_q.push_back(vecs[idx]); id_q.push_back(idx);
          idx++;
        end else begin
          fs_to_ds_valid = 0;
        end
      end
      if (guard >= 200) begin
        n_checks++; n_errs++;
        $display("FAIL table drain: got %0d pending expected 0", sb_q.size());
      end
    end
    @(negedge clk) fs_to_ds_valid = 0;
    check("after table idle", 32'(ds_to_es_valid), 0);

    // ---------------- load-use: ld.w r4 in EXE, add.w r5,r4,r0 in ID ----------------
    @(negedge clk) begin
      fs_to_ds_valid = 1; fs_pc = 32'h1C00_0500; fs_inst = 32'h0010_0085;
      es_valid = 1; es_gr_we = 1; es_res_from_mem = 1; es_dest = 4; es_result = 32'h0000_DEAD;
    end
    @(negedge clk) fs_to_ds_valid = 0;
    #1;
    check("lu es stall valid",   32'(ds_to_es_valid), 0);
    check("lu es stall allowin", 32'(ds_allowin), 0);
    check("lu es stall br",      32'(br_taken), 0);
    @(negedge clk) begin
      idle_stages(); ms_valid = 1; ms_gr_we = 1; ms_dest = 4; ms_result = 32'h0000_1234;
    end
    #1;
`ifdef ID_BYPASS_EN
    check("lu ms go",      32'(ds_to_es_valid), 1);
    check("lu ms fwd rj",  ds_rj_value, 32'h0000_1234);
    check("lu ms rkd r0",  ds_rkd_value, 0);
`else
    check("lu ms stall",   32'(ds_to_es_valid), 0);
    @(negedge clk) begin
      idle_stages(); wb_valid = 1; wb_gr_we = 1; wb_dest = 4; wb_final_result = 32'h0000_1234;
    end
    #1 check("lu wb stall", 32'(ds_to_es_valid), 0);
    @(negedge clk) idle_stages();
    #1;
    check("lu rf go",      32'(ds_to_es_valid), 1);
    check("lu rf rj",      ds_rj_value, 32'h0000_1234);
    check("lu rf rkd r0",  ds_rkd_value, 0);
`endif
    check("lu pc", ds_pc, 32'h1C00_0500);
    @(negedge clk) idle_stages();
    #1 check("lu handed off", 32'(ds_to_es_valid), 0);

    // ---------------- r0: never forwarded, never a hazard ----------------
    @(negedge clk) begin
      fs_to_ds_valid = 1; fs_pc = 32'h1C00_0600; fs_inst = 32'h0010_0003;
      es_valid = 1; es_gr_we = 1; es_res_from_mem = 1; es_dest = 0; es_result = 32'h0000_0BAD;
      ms_valid = 1; ms_gr_we = 1; ms_dest = 0; ms_result = 32'h0000_0BAD;
    end
    @(negedge clk) fs_to_ds_valid = 0;
    #1;
    check("r0 no stall", 32'(ds_to_es_valid), 1);
    check("r0 rj",       ds_rj_value, 0);
    check("r0 rkd",      ds_rkd_value, 0);
    @(negedge clk) idle_stages();

    // ---------------- backpressure: EXE blocked for 3 cycles ----------------
    @(negedge clk) begin fs_to_ds_valid = 1; fs_pc = 32'h1C00_0700; fs_inst = 32'h0010_0823; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      es_allowin = 0; fs_to_ds_valid = 1; fs_pc = 32'h0000_BAD0 + 32'(k);
      fs_inst = (k % 2 == 0) ? 32'h0011_0828 : 32'hFFFF_FFFF;
      #1;
      check($sformatf("bp%0d allowin", k), 32'(ds_allowin), 0);
      check($sformatf("bp%0d pc", k),      ds_pc, 32'h1C00_0700);
      check($sformatf("bp%0d alu", k),     32'(ds_alu_op), 32'h001);
      check($sformatf("bp%0d rj", k),      ds_rj_value, exp_rf[1]);
      check($sformatf("bp%0d rkd", k),     ds_rkd_value, exp_rf[2]);
      check($sformatf("bp%0d dest", k),    32'(ds_dest), 3);
    end
    @(negedge clk) begin es_allowin = 1; fs_to_ds_valid = 0; end
    #1;
    check("bp resume valid", 32'(ds_to_es_valid), 1);
    check("bp resume pc",    ds_pc, 32'h1C00_0700);
    @(negedge clk);
    check("bp drained", 32'(ds_to_es_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
